// File: rtl/spmv_sequencer.sv
// spmv_sequencer: sparse matrix-vector multiply sequencer.
//
// Walks a packed nonzero-entry memory (one 32-bit word per entry:
// [31:24] row, [23:16] col, [15:0] signed value; 0x00000000 terminates).
// For each entry it fetches the matching dense-vector element, multiplies and
// accumulates per row, and emits one (row, sum) per nonempty row over a
// valid/ready handshake. Rows are expected in nondecreasing order; a decrease
// sets the sticky errUnsorted flag.
//
// Ports:
//   clk, reset       clock, synchronous active-low reset
//   start            begin a pass (sampled only when idle)
//   numEntries       entry count, sampled with start
//   busy, done       status: busy whenever not idle, done is a 1-cycle pulse
//   errUnsorted      sticky: row index decreased within the pass
//   matRen/matAddr   entry-memory read port, matData valid one cycle later
//   vecRen/vecAddr   vector-memory read port, vecData valid one cycle later
//   resValid/resReady/resRow/resSum  result handshake
module spmv_sequencer #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned IDX_W  = 8,
  parameter int unsigned ACC_W  = 40
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] numEntries,
  output logic              busy,
  output logic              done,
  output logic              errUnsorted,
  output logic              matRen,
  output logic [ADDR_W-1:0] matAddr,
  input  logic [31:0]       matData,
  output logic              vecRen,
  output logic [IDX_W-1:0]  vecAddr,
  input  logic [15:0]       vecData,
  output logic              resValid,
  input  logic              resReady,
  output logic [IDX_W-1:0]  resRow,
  output logic [ACC_W-1:0]  resSum
);

  typedef enum logic [2:0] {
    StIdle,
    StMreq,
    StMlat,
    StVreq,
    StVlat,
    StEmit,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  num_q, num_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [IDX_W-1:0]   cur_row_q, cur_row_d;
  logic               have_row_q, have_row_d;
  logic               pending_q, pending_d;
  logic [IDX_W-1:0]   row_q, row_d;
  logic [IDX_W-1:0]   col_q, col_d;
  logic [15:0]        val_q, val_d;
  logic               err_q, err_d;

  // Field decode of the entry word currently on matData.
  logic [IDX_W-1:0]   word_row;
  logic [IDX_W-1:0]   word_col;
  logic signed [31:0] prod;
  logic [ACC_W-1:0]   prod_ext;

  assign word_row = IDX_W'(matData[31:24]);
  assign word_col = IDX_W'(matData[23:16]);

  // 16x16 signed product is exactly 32 bits; sign-extend into the accumulator.
  assign prod     = 32'($signed(val_q)) * 32'($signed(vecData));
  assign prod_ext = ACC_W'(prod);

  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    ptr_d       = ptr_q;
    acc_d       = acc_q;
    cur_row_d   = cur_row_q;
    have_row_d  = have_row_q;
    pending_d   = pending_q;
    row_d       = row_q;
    col_d       = col_q;
    val_d       = val_q;
    err_d       = err_q;

    busy        = (state_q != StIdle);
    done        = 1'b0;
    matRen      = 1'b0;
    matAddr     = '0;
    vecRen      = 1'b0;
    vecAddr     = '0;
    resValid    = 1'b0;
    resRow      = '0;
    resSum      = '0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          num_d      = numEntries;
          err_d      = 1'b0;
          ptr_d      = '0;
          have_row_d = 1'b0;
          acc_d      = '0;
          pending_d  = 1'b0;
          state_d    = (numEntries == '0) ? StDone : StMreq;
        end
      end

      StMreq: begin
        matRen  = 1'b1;
        matAddr = ptr_q;
        state_d = StMlat;
      end

      StMlat: begin
        if (matData == 32'h0) begin
          // Terminator: flush the open row if there is one.
          pending_d = 1'b0;
          state_d   = have_row_q ? StEmit : StDone;
        end else begin
          row_d = word_row;
          col_d = word_col;
          val_d = matData[15:0];
          if (!have_row_q) begin
            cur_row_d  = word_row;
            have_row_d = 1'b1;
            acc_d      = '0;
            state_d    = StVreq;
          end else if (word_row == cur_row_q) begin
            state_d = StVreq;
          end else begin
            // Row change: emit the finished row first, then resume this entry.
            pending_d = 1'b1;
            if (word_row < cur_row_q) begin
              err_d = 1'b1;
            end
            state_d = StEmit;
          end
        end
      end

      StVreq: begin
        vecRen  = 1'b1;
        vecAddr = col_q;
        state_d = StVlat;
      end

      StVlat: begin
        acc_d = acc_q + prod_ext;
        ptr_d = ptr_q + ADDR_W'(1);
        if (ptr_d == num_q) begin
          pending_d = 1'b0;
          state_d   = StEmit;
        end else begin
          state_d = StMreq;
        end
      end

      StEmit: begin
        resValid = 1'b1;
        resRow   = cur_row_q;
        resSum   = acc_q;
        if (resReady) begin
          if (pending_q) begin
            acc_d     = '0;
            cur_row_d = row_q;
            pending_d = 1'b0;
            state_d   = StVreq;
          end else begin
            state_d = StDone;
          end
        end
      end

      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign errUnsorted = err_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      num_q      <= '0;
      ptr_q      <= '0;
      acc_q      <= '0;
      cur_row_q  <= '0;
      have_row_q <= 1'b0;
      pending_q  <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      val_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      ptr_q      <= ptr_d;
      acc_q      <= acc_d;
      cur_row_q  <= cur_row_d;
      have_row_q <= have_row_d;
      pending_q  <= pending_d;
      row_q      <= row_d;
      col_q      <= col_d;
      val_q      <= val_d;
      err_q      <= err_d;
    end
  end

endmodule
